// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] INST_BYTES      = 32'd4;
    localparam int          FETCH_MAX_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO holding fetched words with their PCs; flush empties it in one cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, tracks in-flight reads, buffers words for the decoder.
// Optional: FETCH_ALIGN_CHECK_EN adds misalign_o and halts fetch on a misaligned redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > FETCH_MAX_DEPTH) begin : g_depth_check
        $error("fetch_unit: DEPTH must be within 1..FETCH_MAX_DEPTH");
    end

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_use;
    logic             started;
    logic             halted;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_keep;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     fifo_head;

    // A slot is held from request acceptance until the word leaves the FIFO,
    // so the FIFO can never be asked to take more than it has room for.
    assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign credit_ok = !fifo_full && (in_use < (CNT_W + 1)'(DEPTH));

    assign mem_req_valid_o = started && !halted && !redirect_i && credit_ok;
    assign mem_req_addr_o  = fetch_pc;
    assign req_fire        = mem_req_valid_o && mem_req_ready_i;
    assign rsp_keep        = mem_rsp_valid_i && !redirect_i && (discard == '0);
    assign push_entry      = '{pc: resp_pc, inst: mem_rsp_data_i};

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            misalign_o <= 1'b0;
        end else if (redirect_i) begin
            misalign_o <= (redirect_pc_i[1:0] != 2'b00);
        end
    end
    assign halted = misalign_o;
`else
    assign halted = 1'b0;
`endif

    // started keeps the request low until the first edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            started <= 1'b1;
            if (redirect_i) begin
                fetch_pc    <= align_pc(redirect_pc_i);
                resp_pc     <= align_pc(redirect_pc_i);
                outstanding <= outstanding - CNT_W'(mem_rsp_valid_i);
                discard     <= outstanding - CNT_W'(mem_rsp_valid_i);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + INST_BYTES;
                end
                if (rsp_keep) begin
                    resp_pc <= resp_pc + INST_BYTES;
                end
                if (mem_rsp_valid_i && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
                outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(mem_rsp_valid_i);
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (rsp_keep),
        .push_data(push_entry),
        .pop      (inst_valid_o && inst_ready_i),
        .flush    (redirect_i),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head     (fifo_head)
    );

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? '0 : fifo_head.inst;
    assign inst_pc_o    = fifo_empty ? '0 : fifo_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order variable-latency memory model plus expected-instruction queue.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DMASK    = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o (mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i (mem_rsp_data_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign_o     (misalign_o)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_pc;
    logic [31:0] hold_addr;
    logic        hold_pend;
    int cycle, mem_lat, last_due, ready_pct;
    int n_checks, n_fail, n_spur, n_req, pend_before;
    bit found;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pop_at(input int i);
        return (pop_log.size() > i) ? pop_log[i] : 32'hDEAD_DEAD;
    endfunction

    // One clock cycle: memory drives its response, handshakes are judged at the negedge.
    task automatic step();
        pend_t       p;
        logic [63:0] e;
        int          d;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        if (reset_n && pend_q.size() > 0 && pend_q[0].due <= cycle) begin
            p = pend_q.pop_front();
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = p.addr ^ DMASK;
        end
        mem_req_ready_i = ($urandom_range(99) < ready_pct);
        @(negedge clock);
        if (reset_n) begin
            if (hold_pend && !redirect_i) begin
                chk("req_hold_valid", mem_req_valid_o, 1'b1);
                chk("req_hold_addr", mem_req_addr_o, hold_addr);
            end
            if (redirect_i) begin
                chk("redir_no_req", mem_req_valid_o, 1'b0);
                exp_q.delete();
                pop_log.delete();
                exp_pc = {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (mem_req_valid_o && mem_req_ready_i) begin
                    chk("req_addr", mem_req_addr_o, exp_pc);
                    exp_q.push_back({exp_pc, exp_pc ^ DMASK});
                    exp_pc = exp_pc + 32'd4;
                end
                if (inst_valid_o && inst_ready_i) begin
                    pop_log.push_back(inst_pc_o);
                    if (exp_q.size() == 0) begin
                        n_spur++;
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_pc", inst_pc_o, e[63:32]);
                        chk("inst", inst_o, e[31:0]);
                    end
                end
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                n_req++;
                d = cycle + mem_lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend_q.push_back('{addr: mem_req_addr_o, due: d});
            end
            hold_pend = mem_req_valid_o && !mem_req_ready_i;
            hold_addr = mem_req_addr_o;
        end
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic run_until_pops(input int n, input int budget);
        for (int i = 0; i < budget && pop_log.size() < n; i++) step();
        chk("pop_budget", 32'(pop_log.size() >= n), 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        step();
        redirect_i    = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
        mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
        ready_pct = 100; mem_lat = 1; exp_pc = RESET_PC; cycle = 0; last_due = 0;
        n_checks = 0; n_fail = 0; n_spur = 0; n_req = 0; hold_pend = 1'b0; hold_addr = '0;

        // Reset held three cycles with memory ready
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req_valid", mem_req_valid_o, 1'b0);
            chk("rst_inst_valid", inst_valid_o, 1'b0);
        end
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        chk("rst_req_addr", mem_req_addr_o, RESET_PC);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_misalign", misalign_o, 1'b0);
`endif
        reset_n = 1'b1;

        // Backpressure: downstream stalled, only DEPTH requests may go out
        n_req = 0;
        repeat (10) step();
        chk("bp_req_count", n_req, 32'd2);
        chk("bp_inst_valid", inst_valid_o, 1'b1);
        chk("bp_inst_pc", inst_pc_o, 32'h0);
        chk("bp_inst", inst_o, 32'h0 ^ DMASK);
        inst_ready_i = 1'b1;
        run_until_pops(2, 10);
        chk("bp_first_pc", pop_at(0), 32'h0);
        chk("bp_second_pc", pop_at(1), 32'h4);

        // Streaming with a 1-cycle memory and occasional request stalls
        ready_pct = 70;
        pop_log.delete();
        repeat (40) step();
        chk("stream_progress", 32'(pop_log.size() >= 10), 32'd1);

        // Redirect with two requests in flight on a 3-cycle memory
        ready_pct = 100;
        mem_lat = 3;
        for (int i = 0; i < 50 && pend_q.size() != 2; i++) step();
        chk("redir_outstanding", pend_q.size(), 32'd2);
        redirect_to(32'h0000_0100);
        run_until_pops(2, 40);
        chk("redir_first_pc", pop_at(0), 32'h0000_0100);

        // Redirect, response and pop all in one cycle
        mem_lat = 2;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (pend_q.size() > 0 && pend_q[0].due <= cycle && inst_valid_o) found = 1'b1;
            else step();
        end
        chk("sim_found", found, 1'b1);
        pend_before = pend_q.size();
        redirect_to(32'h0000_0200);
        chk("sim_fifo_empty", inst_valid_o, 1'b0);
        chk("sim_discard", 32'(dut.discard), 32'(pend_before - 1));
        run_until_pops(2, 40);
        chk("sim_first_pc", pop_at(0), 32'h0000_0200);

        // Address wrap at the top of the space
        mem_lat = 1;
        redirect_to(32'hFFFF_FFFC);
        run_until_pops(2, 40);
        chk("wrap_first_pc", pop_at(0), 32'hFFFF_FFFC);
        chk("wrap_second_pc", pop_at(1), 32'h0000_0000);

`ifdef FETCH_ALIGN_CHECK_EN
        redirect_to(32'h0000_0102);
        n_req = 0;
        repeat (8) step();
        chk("mis_flag", misalign_o, 1'b1);
        chk("mis_no_req", n_req, 32'd0);
        chk("mis_no_inst", inst_valid_o, 1'b0);
        redirect_to(32'h0000_0200);
        chk("mis_clear", misalign_o, 1'b0);
        run_until_pops(2, 40);
        chk("mis_resume_pc", pop_at(0), 32'h0000_0200);
`else
        redirect_to(32'h0000_0302);
        run_until_pops(2, 40);
        chk("lowbits_forced_pc", pop_at(0), 32'h0000_0300);
`endif

        // Reset in the middle of streaming; memory drops its in-flight reads
        ready_pct = 70;
        mem_lat = 2;
        repeat (7) step();
        reset_n = 1'b0;
        pend_q.delete(); exp_q.delete(); pop_log.delete();
        exp_pc = RESET_PC; last_due = cycle; hold_pend = 1'b0;
        #1;
        chk("midrst_req_valid", mem_req_valid_o, 1'b0);
        chk("midrst_inst_valid", inst_valid_o, 1'b0);
        chk("midrst_req_addr", mem_req_addr_o, RESET_PC);
        repeat (2) step();
        reset_n = 1'b1;
        run_until_pops(3, 60);
        chk("midrst_first_pc", pop_at(0), RESET_PC);

        repeat (5) step();
        chk("no_spurious_pops", n_spur, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
